// File: rtl/av_mult_scheduler_if.sv
// rtl/av_mult_scheduler_if.sv - request, engine and response signal bundle for av_mult_scheduler
interface av_mult_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_prec;
  logic                 eng_start;
  logic [ID_W-1:0]      eng_sel;
  logic [3:0]           eng_prec;
  logic                 eng_done;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_err;
  logic                 rsp_ready;
  logic                 busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_prec, eng_done, rsp_ready,
    output req_ready, eng_start, eng_sel, eng_prec, rsp_valid, rsp_id, rsp_err, busy
  );

  // Requesters, engine and response consumer side.
  modport master (
    output req_valid, req_prec, eng_done, rsp_ready,
    input  req_ready, eng_start, eng_sel, eng_prec, rsp_valid, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/av_mult_scheduler.sv
// rtl/av_mult_scheduler.sv - round-robin job scheduler for one shared attention_av_multiply engine; optional watchdog under AV_SCHED_TIMEOUT_EN
module av_mult_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  av_mult_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("av_mult_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_eng_sel;
  logic [3:0]          r_eng_prec;
  logic [ID_W-1:0]     w_grant_idx;
  logic [ID_W-1:0]     w_cand;
  logic                w_any_req;
  logic                w_grant;
  logic                w_timeout;
  logic                w_rsp_err;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_eng_start;
  logic                w_rsp_valid;
  logic                w_busy;

  // Pick the first requesting index at or after rr_ptr, wrapping; scanning downward lets the nearest one win.
  always_comb begin
    w_grant_idx = '0;
    w_cand      = '0;
    w_any_req   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[w_cand]) begin
        w_grant_idx = w_cand;
        w_any_req   = 1'b1;
      end
    end
  end

  // Gated by rst_n so no accept strobe can appear while the block is held in reset.
  assign w_grant = rst_n && (r_state == S_IDLE) && w_any_req;

`ifdef AV_SCHED_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_rsp_err;

  assign w_timeout = (r_state == S_WAIT) && !bus.eng_done &&
                     (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign w_rsp_err = r_rsp_err;

  // Watchdog sits at zero outside S_WAIT, so every entry to S_WAIT starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state != S_WAIT) begin
      r_wdog <= '0;
    end else if (!bus.eng_done) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  // Record the job outcome when leaving S_WAIT; a real completion beats a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (bus.eng_done) begin
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes; eng_done only matters while waiting on the engine.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_eng_start = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_grant) begin
          w_req_ready = NUM_REQ'(1) << w_grant_idx;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_eng_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the granted job's operand select and precision, and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_eng_sel  <= '0;
      r_eng_prec <= '0;
    end else if (w_grant) begin
      r_eng_sel  <= w_grant_idx;
      r_eng_prec <= bus.req_prec[{w_grant_idx, 2'b00} +: 4];
      r_rr_ptr   <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.eng_start = w_eng_start;
  assign bus.eng_sel   = r_eng_sel;
  assign bus.eng_prec  = r_eng_prec;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = r_eng_sel;
  assign bus.rsp_err   = w_rsp_err;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_av_mult_scheduler.sv
// tb/tb_av_mult_scheduler.sv - randomized self-checking bench for av_mult_scheduler against a job-level reference model
module tb_av_mult_scheduler;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int PW = 4 * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  av_mult_scheduler_if #(.NUM_REQ(N)) bus ();

  av_mult_scheduler #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ref_ptr  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester found walking up from the pointer, modulo N.
  function automatic int model_grant(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One job, cycle by cycle. mode 0: done after 'delay' wait cycles; 1: no done; 2: done on the timeout cycle.
  task automatic run_job(input logic [N-1:0] mask, input logic [PW-1:0] prec, input int mode,
                         input int delay, input int bp, input bit hold, output int g);
    int         wait_n;
    bit         send_done;
    logic       exp_err;
    logic [3:0] exp_prec;
    send_done = 1'b1;
    exp_err   = 1'b0;
    wait_n    = delay;
    if (mode == 1) begin
`ifdef AV_SCHED_TIMEOUT_EN
      wait_n    = TO;
      send_done = 1'b0;
      exp_err   = 1'b1;
`else
      wait_n    = 3 * TO;
`endif
    end else if (mode == 2) begin
      wait_n = TO - 1;
    end

    next_cycle();
    bus.req_valid = mask;
    bus.req_prec  = prec;
    bus.eng_done  = 1'b0;
    bus.rsp_ready = 1'($urandom);
    #1;
    g        = model_grant(mask, ref_ptr);
    exp_prec = prec[4*g +: 4];
    check_eq("grant_ready", 32'(bus.req_ready), 32'(1 << g));
    check_eq("grant_busy", 32'(bus.busy), 32'(0));
    check_eq("grant_no_start", 32'(bus.eng_start), 32'(0));
    ref_ptr = (g + 1) % N;

    next_cycle();
    if (!hold) bus.req_valid = mask & ~(N'(1) << g);
    bus.req_prec = PW'($urandom);
    bus.eng_done = 1'($urandom);
    #1;
    check_eq("start_pulse", 32'(bus.eng_start), 32'(1));
    check_eq("start_sel", 32'(bus.eng_sel), 32'(g));
    check_eq("start_prec", 32'(bus.eng_prec), 32'(exp_prec));
    check_eq("start_no_ready", 32'(bus.req_ready), 32'(0));
    check_eq("start_busy", 32'(bus.busy), 32'(1));

    for (int i = 0; i < wait_n; i++) begin
      next_cycle();
      bus.eng_done = 1'b0;
      #1;
      check_eq("wait_no_start", 32'(bus.eng_start), 32'(0));
      check_eq("wait_no_rsp", 32'(bus.rsp_valid), 32'(0));
      check_eq("wait_no_ready", 32'(bus.req_ready), 32'(0));
    end
    if (send_done) begin
      next_cycle();
      bus.eng_done = 1'b1;
      #1;
      check_eq("done_cycle_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end

    for (int i = 0; i <= bp; i++) begin
      next_cycle();
      bus.eng_done  = 1'($urandom);
      bus.rsp_ready = (i == bp);
      #1;
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(1));
      check_eq("rsp_id", 32'(bus.rsp_id), 32'(g));
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      check_eq("rsp_no_start", 32'(bus.eng_start), 32'(0));
      check_eq("rsp_no_ready", 32'(bus.req_ready), 32'(0));
      check_eq("rsp_prec_hold", 32'(bus.eng_prec), 32'(exp_prec));
    end

    next_cycle();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.eng_done  = 1'($urandom);
    #1;
    check_eq("post_idle", 32'(bus.busy), 32'(0));
    check_eq("post_no_rsp", 32'(bus.rsp_valid), 32'(0));
  endtask

  initial begin
    int            g;
    int            r;
    logic [N-1:0]  m;
    bus.req_valid = '0;
    bus.req_prec  = '0;
    bus.eng_done  = 1'b0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'(0));
    check_eq("rst_start", 32'(bus.eng_start), 32'(0));
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
    check_eq("rst_sel", 32'(bus.eng_sel), 32'(0));
    check_eq("rst_prec", 32'(bus.eng_prec), 32'(0));
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_job('1, PW'($urandom), 0, 2, 0, 1'b1, g);
      check_eq("fair_order", 32'(g), 32'(i % 4));
    end

`ifdef AV_SCHED_TIMEOUT_EN
    run_job(N'(4'b0100), PW'(16'h0200), 0, 4, 0, 1'b0, g);
`else
    run_job(N'(4'b0100), PW'(16'h0200), 0, 9, 0, 1'b0, g);
`endif
    check_eq("single_job_id", 32'(g), 32'(2));

    run_job(N'($urandom_range(1, 15)), PW'($urandom), 0, 3, 5, 1'b0, g);
    run_job(N'($urandom_range(1, 15)), PW'($urandom), 1, 0, 2, 1'b0, g);
    run_job(N'($urandom_range(1, 15)), PW'($urandom), 2, 0, 1, 1'b0, g);

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.req_valid = '0;
      bus.eng_done  = 1'($urandom);
      #1;
      check_eq("idle_no_ready", 32'(bus.req_ready), 32'(0));
      check_eq("idle_busy", 32'(bus.busy), 32'(0));
    end

    next_cycle();
    bus.req_valid = N'(4'b0010);
    bus.req_prec  = PW'($urandom);
    bus.eng_done  = 1'b0;
    #1;
    g = model_grant(N'(4'b0010), ref_ptr);
    check_eq("rstjob_grant", 32'(bus.req_ready), 32'(1 << g));
    next_cycle();
    bus.req_valid = '0;
    #1;
    check_eq("rstjob_start", 32'(bus.eng_start), 32'(1));
    next_cycle();
    #1;
    check_eq("rstjob_wait_busy", 32'(bus.busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(bus.busy), 32'(0));
    check_eq("midrst_start", 32'(bus.eng_start), 32'(0));
    check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check_eq("midrst_rsp_err", 32'(bus.rsp_err), 32'(0));
    check_eq("midrst_sel", 32'(bus.eng_sel), 32'(0));
    check_eq("midrst_prec", 32'(bus.eng_prec), 32'(0));
    next_cycle();
    bus.req_valid = '1;
    #1;
    check_eq("midrst_no_ready", 32'(bus.req_ready), 32'(0));
    next_cycle();
    rst_n         = 1'b1;
    ref_ptr       = 0;
    bus.req_valid = '0;
    bus.eng_done  = 1'b1;
    #1;
    check_eq("stale_done_busy", 32'(bus.busy), 32'(0));
    next_cycle();
    bus.eng_done = 1'b0;
    #1;
    check_eq("stale_done_no_rsp", 32'(bus.rsp_valid), 32'(0));
    check_eq("stale_done_idle", 32'(bus.busy), 32'(0));
    run_job('1, PW'($urandom), 0, 1, 0, 1'b0, g);
    check_eq("post_reset_grant", 32'(g), 32'(0));

    for (int i = 0; i < 30; i++) begin
      m = N'($urandom);
      if (m == '0) m = N'(1) << $urandom_range(0, N - 1);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        run_job(m, PW'($urandom), 1, 0, $urandom_range(0, 3), 1'b0, g);
      end else if (r == 1) begin
        run_job(m, PW'($urandom), 2, 0, $urandom_range(0, 3), 1'b0, g);
      end else begin
        run_job(m, PW'($urandom), 0, $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom), g);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/av_mult_scheduler.md
AV_MULT_SCHEDULER -- requirements
Module: av_mult_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one attention_av_multiply engine; legal range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles while in S_WAIT; legal range 1..65535.
REQ-003 Localparam ID_W = $clog2(NUM_REQ).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester job request; held until accepted.
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe; at most one bit high in any cycle.
REQ-008 req_prec  input  4*NUM_REQ  per-requester precision code; requester i uses bits [4i+3:4i].
REQ-009 eng_start  output  1  single-cycle start pulse to the engine.
REQ-010 eng_sel  output  ID_W  granted requester index; drives the A/V operand muxes.
REQ-011 eng_prec  output  4  latched precision code of the granted job.
REQ-012 eng_done  input  1  engine completion pulse.
REQ-013 rsp_valid  output  1  completion response valid.
REQ-014 rsp_id  output  ID_W  requester index of the completed job.
REQ-015 rsp_err  output  1  job terminated by the watchdog.
REQ-016 rsp_ready  input  1  response consumer accept.
REQ-017 busy  output  1  high in every state except S_IDLE.

Function
REQ-018 States: S_IDLE, S_START, S_WAIT, S_RESP, with no other states.
REQ-019 S_IDLE: when any req_valid bit is set, round-robin-grant the lowest-numbered index at or above rr_ptr, wrapping modulo NUM_REQ.
REQ-020 On a grant, req_ready[g] is high combinationally in that same cycle, and the transfer completes when req_valid[g] && req_ready[g].
REQ-021 On a grant, eng_sel <= g, eng_prec <= req_prec[g], rr_ptr <= (g+1) mod NUM_REQ, next state S_START.
REQ-022 S_START: eng_start = 1 for exactly this cycle, then S_WAIT.
REQ-023 req_ready is 0 in S_START, S_WAIT and S_RESP.
REQ-024 eng_sel and eng_prec hold stable from the grant until the next grant.
REQ-025 S_WAIT: eng_done = 1 sets rsp_err <= 0 and moves to S_RESP.
REQ-026 eng_done is ignored in every state other than S_WAIT.
REQ-027 S_RESP: rsp_valid = 1 and rsp_id = eng_sel; return to S_IDLE on the cycle rsp_valid && rsp_ready.
REQ-028 S_RESP: rsp_valid, rsp_id and rsp_err hold stable while rsp_ready is low.
REQ-029 Latency: grant in cycle t gives eng_start in t+1; eng_done in cycle d gives rsp_valid from d+1.
REQ-030 Earliest re-grant is the cycle after the response handshake.
REQ-031 A requester that drops req_valid before its grant is not served and leaves no state behind.

Reset
REQ-032 On rst_n low: state = S_IDLE, rr_ptr = 0, eng_sel = 0, eng_prec = 0, wdog = 0.
REQ-033 On rst_n low: eng_start = 0, req_ready = 0, rsp_valid = 0, rsp_err = 0, busy = 0.
REQ-034 Reset asserted mid-job abandons the job and produces no response for it.
REQ-035 After reset, an eng_done arriving from the abandoned job is ignored.

Configuration
REQ-036 Macro AV_SCHED_TIMEOUT_EN controls the watchdog counter wdog, $clog2(TIMEOUT_CYCLES+1) bits wide.
REQ-037 With the macro defined: wdog clears on entry to S_WAIT and increments each S_WAIT cycle without eng_done.
REQ-038 With the macro defined: when wdog reaches TIMEOUT_CYCLES-1 without eng_done, set rsp_err <= 1 and move to S_RESP.
REQ-039 With the macro defined: eng_done in the same cycle as the timeout wins, giving rsp_err = 0.
REQ-040 Without the macro: no wdog logic exists, rsp_err is constant 0, and S_WAIT waits indefinitely for eng_done.

Verification
REQ-041 Single job: req_valid = 4'b0100, req_prec[11:8] = 2; expect req_ready = 4'b0100 in cycle t, eng_start in t+1 with eng_sel = 2 and eng_prec = 2; eng_done 10 cycles later gives rsp_valid, rsp_id = 2, rsp_err = 0.
REQ-042 Fairness: all four req_valid held high for four jobs; expect grant order 0,1,2,3, then 0 again on a fifth job.
REQ-043 Backpressure: rsp_ready held low 5 cycles in S_RESP; expect rsp_valid, rsp_id and rsp_err stable, no eng_start and no req_ready until the handshake.
REQ-044 Timeout (macro on, TIMEOUT_CYCLES = 8): no eng_done; expect rsp_valid 8 cycles after entering S_WAIT with rsp_err = 1; a later eng_done has no effect.
REQ-045 Tie: eng_done on the exact timeout cycle gives rsp_err = 0.
REQ-046 Reset: rst_n pulsed low during S_WAIT; expect all outputs 0 at once, no response, and the next grant starts from index 0.
